// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with an integrated register file and an ID/EX
// pipeline register. It has a valid/ready handshake, flush, a load-use
// interlock, optional write-back bypass, and held-operand refresh.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PC_W   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_flush,
  input  logic            i_ex_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_imm,
  output logic [PC_W-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_func3,
  output logic            o_func7b5,
  output logic            o_rf_we,
  output logic            o_is_load,
  output logic            o_illegal
);

  localparam int AW = (NREG > 16) ? 5 : 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7b5;
    logic            rf_we;
    logic            is_load;
    logic            illegal;
  } bundle_t;

  // A register index outside the implemented file (x16..x31 when NREG=16).
  function automatic logic idx_oor(input logic [4:0] idx);
    return ({27'd0, idx} >= NREG);
  endfunction

  // Sign-extended immediate for the instruction's format; formats without
  // an immediate (OP, unknown) give 0.
  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OPC_LOAD, OPC_JALR, OPC_OPIMM: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ins[31:12], 12'd0};
      OPC_JAL:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:    imm = 32'd0;
    endcase
    return imm;
  endfunction

  logic [XLEN-1:0] rf_q [NREG];
  bundle_t         bundle_q, bundle_d, dec_s;
  logic            valid_q, valid_d;
  logic            uses_rs1_s, uses_rs2_s, writes_rd_s, known_s, illegal_s;
  logic [4:0]      rs1_idx_s, rs2_idx_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s;
  logic            wb_eff_s, load_use_s, accept_s;

  assign wb_eff_s = i_wb_we & (i_wb_rd != 5'd0) & ~idx_oor(i_wb_rd);

  // Opcode classification: which source registers are read and whether rd is written.
  always_comb begin
    uses_rs1_s  = 1'b0;
    uses_rs2_s  = 1'b0;
    writes_rd_s = 1'b0;
    known_s     = 1'b1;
    case (i_instr[6:0])
      OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
        uses_rs1_s  = 1'b1;
        writes_rd_s = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OPC_OP: begin
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b1;
        writes_rd_s = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd_s = 1'b1;
      default: known_s = 1'b0;
    endcase
    rs1_idx_s = uses_rs1_s ? i_instr[19:15] : 5'd0;
    rs2_idx_s = uses_rs2_s ? i_instr[24:20] : 5'd0;
    illegal_s = ~known_s | idx_oor(rs1_idx_s) | idx_oor(rs2_idx_s)
              | (writes_rd_s & idx_oor(i_instr[11:7]));
  end

  // Operand read: x0 and out-of-range indices read 0, optional same-cycle bypass.
  always_comb begin
    if (rs1_idx_s == 5'd0 || idx_oor(rs1_idx_s)) begin
      rs1_data_s = '0;
    end else if (BYPASS != 0 && wb_eff_s && i_wb_rd == rs1_idx_s) begin
      rs1_data_s = i_wb_data;
    end else begin
      rs1_data_s = rf_q[rs1_idx_s[AW-1:0]];
    end
    if (rs2_idx_s == 5'd0 || idx_oor(rs2_idx_s)) begin
      rs2_data_s = '0;
    end else if (BYPASS != 0 && wb_eff_s && i_wb_rd == rs2_idx_s) begin
      rs2_data_s = i_wb_data;
    end else begin
      rs2_data_s = rf_q[rs2_idx_s[AW-1:0]];
    end
  end

  // Assemble the decoded bundle that would be captured on acceptance.
  always_comb begin
    dec_s.rs1_data = rs1_data_s;
    dec_s.rs2_data = rs2_data_s;
    dec_s.imm      = XLEN'($signed(imm_gen(i_instr)));
    dec_s.pc       = i_pc;
    dec_s.rs1      = rs1_idx_s;
    dec_s.rs2      = rs2_idx_s;
    dec_s.rd       = i_instr[11:7];
    dec_s.opcode   = i_instr[6:0];
    dec_s.func3    = i_instr[14:12];
    dec_s.func7b5  = i_instr[30];
    dec_s.rf_we    = writes_rd_s & (i_instr[11:7] != 5'd0) & ~illegal_s;
    dec_s.is_load  = (i_instr[6:0] == OPC_LOAD) & ~illegal_s;
    dec_s.illegal  = illegal_s;
  end

  // Load-use interlock: the incoming instruction needs the held load's result.
  // Unused sources carry index 0 and rd must be nonzero, so they never match.
  assign load_use_s = i_valid & valid_q & bundle_q.is_load & (bundle_q.rd != 5'd0)
                    & ((rs1_idx_s == bundle_q.rd) | (rs2_idx_s == bundle_q.rd));

  assign o_ready  = rst | i_flush | ((~valid_q | i_ex_ready) & ~load_use_s);
  assign accept_s = i_valid & o_ready;

  // Pipeline register next state: flush kills, a free slot loads or bubbles,
  // a held slot keeps its bundle but refreshes operands from write-back.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (~valid_q | i_ex_ready) begin
      if (accept_s) begin
        valid_d  = 1'b1;
        bundle_d = dec_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      if (wb_eff_s && bundle_q.rs1 == i_wb_rd) begin
        bundle_d.rs1_data = i_wb_data;
      end else begin
        bundle_d.rs1_data = bundle_q.rs1_data;
      end
      if (wb_eff_s && bundle_q.rs2 == i_wb_rd) begin
        bundle_d.rs2_data = i_wb_data;
      end else begin
        bundle_d.rs2_data = bundle_q.rs2_data;
      end
    end
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  // Register file: cleared on reset, written by write-back even during flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_eff_s) begin
      rf_q[i_wb_rd[AW-1:0]] <= i_wb_data;
    end
  end

  assign o_valid    = valid_q;
  assign o_rs1_data = bundle_q.rs1_data;
  assign o_rs2_data = bundle_q.rs2_data;
  assign o_imm      = bundle_q.imm;
  assign o_pc       = bundle_q.pc;
  assign o_rs1      = bundle_q.rs1;
  assign o_rs2      = bundle_q.rs2;
  assign o_rd       = bundle_q.rd;
  assign o_opcode   = bundle_q.opcode;
  assign o_func3    = bundle_q.func3;
  assign o_func7b5  = bundle_q.func7b5;
  assign o_rf_we    = bundle_q.rf_we;
  assign o_is_load  = bundle_q.is_load;
  assign o_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: three instances share the stimulus
// (bypass on, bypass off, RV32E with bypass on).
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, i_valid, i_wb_we, i_flush, i_ex_ready;
  logic [31:0] i_instr, i_pc, i_wb_data;
  logic [4:0]  i_wb_rd;
  int          passed = 0;
  int          total  = 0;

  logic        b_ready, b_valid, b_f7, b_rf_we, b_is_load, b_illegal;
  logic [31:0] b_rs1_data, b_rs2_data, b_imm, b_pc;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_opcode;
  logic [2:0]  b_func3;
  logic        n_ready, n_valid, n_f7, n_rf_we, n_is_load, n_illegal;
  logic [31:0] n_rs1_data, n_rs2_data, n_imm, n_pc;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [6:0]  n_opcode;
  logic [2:0]  n_func3;
  logic        e_ready, e_valid, e_f7, e_rf_we, e_is_load, e_illegal;
  logic [31:0] e_rs1_data, e_rs2_data, e_imm, e_pc;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [6:0]  e_opcode;
  logic [2:0]  e_func3;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREG(32), .PC_W(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(b_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush),
    .i_ex_ready(i_ex_ready), .o_valid(b_valid), .o_rs1_data(b_rs1_data), .o_rs2_data(b_rs2_data),
    .o_imm(b_imm), .o_pc(b_pc), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd), .o_opcode(b_opcode),
    .o_func3(b_func3), .o_func7b5(b_f7), .o_rf_we(b_rf_we), .o_is_load(b_is_load), .o_illegal(b_illegal));

  id_stage_pipe #(.XLEN(32), .NREG(32), .PC_W(32), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(n_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush),
    .i_ex_ready(i_ex_ready), .o_valid(n_valid), .o_rs1_data(n_rs1_data), .o_rs2_data(n_rs2_data),
    .o_imm(n_imm), .o_pc(n_pc), .o_rs1(n_rs1), .o_rs2(n_rs2), .o_rd(n_rd), .o_opcode(n_opcode),
    .o_func3(n_func3), .o_func7b5(n_f7), .o_rf_we(n_rf_we), .o_is_load(n_is_load), .o_illegal(n_illegal));

  id_stage_pipe #(.XLEN(32), .NREG(16), .PC_W(32), .BYPASS(1)) u_e (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(e_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush),
    .i_ex_ready(i_ex_ready), .o_valid(e_valid), .o_rs1_data(e_rs1_data), .o_rs2_data(e_rs2_data),
    .o_imm(e_imm), .o_pc(e_pc), .o_rs1(e_rs1), .o_rs2(e_rs2), .o_rd(e_rd), .o_opcode(e_opcode),
    .o_func3(e_func3), .o_func7b5(e_f7), .o_rf_we(e_rf_we), .o_is_load(e_is_load), .o_illegal(e_illegal));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_instr = 32'd0; i_pc = 32'd0; i_wb_we = 1'b0;
    i_wb_rd = 5'd0; i_wb_data = 32'd0; i_flush = 1'b0; i_ex_ready = 1'b1;
    tick(); tick();
    total++; if (b_ready !== 1'b1) $display("FAIL rst_ready_in_reset: got %0h want 1", b_ready); else passed++;
    rst = 1'b0; #1;
    total++; if (b_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", b_valid); else passed++;
    total++; if (b_ready !== 1'b1) $display("FAIL rst_ready: got %0h want 1", b_ready); else passed++;
    total++; if ({b_rs1_data, b_rs2_data, b_imm, b_pc} !== 128'd0) $display("FAIL rst_data: got %0h want 0", {b_rs1_data, b_rs2_data, b_imm, b_pc}); else passed++;
    total++; if ({b_rs1, b_rs2, b_rd, b_opcode, b_func3, b_f7, b_rf_we, b_is_load, b_illegal} !== 33'd0) $display("FAIL rst_fields: got %0h want 0", {b_rs1, b_rs2, b_rd, b_opcode}); else passed++;
    // addi x6,x5,0 : x5 must read 0 after reset
    i_valid = 1'b1; i_instr = 32'h00028313; i_pc = 32'h10;
    tick();
    i_valid = 1'b0;
    total++; if (b_valid !== 1'b1) $display("FAIL rst_x5_valid: got %0h want 1", b_valid); else passed++;
    total++; if (b_rs1_data !== 32'd0) $display("FAIL rst_x5_data: got %0h want 0", b_rs1_data); else passed++;
    total++; if (b_rs1 !== 5'd5 || b_rd !== 5'd6 || b_pc !== 32'h10) $display("FAIL rst_x5_fields: got rs1=%0d rd=%0d pc=%0h want 5 6 10", b_rs1, b_rd, b_pc); else passed++;
  endtask

  task automatic test_bypass();
    // add x4,x3,x3 while writing back x3=DEADBEEF
    i_valid = 1'b1; i_instr = 32'h00318233; i_pc = 32'h100;
    i_wb_we = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'hDEADBEEF;
    tick();
    i_wb_we = 1'b0; i_pc = 32'h104;
    total++; if (b_rs1_data !== 32'hDEADBEEF || b_rs2_data !== 32'hDEADBEEF) $display("FAIL byp_on: got %0h/%0h want deadbeef", b_rs1_data, b_rs2_data); else passed++;
    total++; if (n_rs1_data !== 32'd0 || n_rs2_data !== 32'd0) $display("FAIL byp_off_old: got %0h/%0h want 0", n_rs1_data, n_rs2_data); else passed++;
    total++; if (b_rd !== 5'd4 || b_opcode !== 7'h33 || b_rf_we !== 1'b1) $display("FAIL byp_fields: got rd=%0d op=%0h we=%0h want 4 33 1", b_rd, b_opcode, b_rf_we); else passed++;
    tick();
    i_valid = 1'b0;
    total++; if (n_rs1_data !== 32'hDEADBEEF) $display("FAIL byp_off_next: got %0h want deadbeef", n_rs1_data); else passed++;
  endtask

  task automatic test_load_use();
    i_valid = 1'b1; i_instr = 32'h0000A383; i_pc = 32'h120; i_ex_ready = 1'b1;  // lw x7,0(x1)
    tick();
    total++; if (b_valid !== 1'b1 || b_is_load !== 1'b1 || b_rd !== 5'd7) $display("FAIL lu_load: got v=%0h ld=%0h rd=%0d want 1 1 7", b_valid, b_is_load, b_rd); else passed++;
    i_instr = 32'h00138413; i_pc = 32'h124;  // addi x8,x7,1
    #1;
    total++; if (b_ready !== 1'b0) $display("FAIL lu_stall_ready: got %0h want 0", b_ready); else passed++;
    tick();
    total++; if (b_valid !== 1'b0) $display("FAIL lu_bubble: got %0h want 0", b_valid); else passed++;
    total++; if (b_ready !== 1'b1) $display("FAIL lu_release: got %0h want 1", b_ready); else passed++;
    tick();
    i_valid = 1'b0;
    total++; if (b_valid !== 1'b1 || b_pc !== 32'h124) $display("FAIL lu_addi_valid: got v=%0h pc=%0h want 1 124", b_valid, b_pc); else passed++;
    total++; if (b_imm !== 32'd1 || b_rd !== 5'd8) $display("FAIL lu_addi_fields: got imm=%0h rd=%0d want 1 8", b_imm, b_rd); else passed++;
    total++; if (b_rs1 !== 5'd7 || b_rs2 !== 5'd0 || b_is_load !== 1'b0) $display("FAIL lu_addi_rs: got rs1=%0d rs2=%0d ld=%0h want 7 0 0", b_rs1, b_rs2, b_is_load); else passed++;
  endtask

  task automatic test_backpressure();
    i_valid = 1'b1; i_instr = 32'h002084B3; i_pc = 32'h200; i_ex_ready = 1'b1;  // add x9,x1,x2
    tick();
    total++; if (b_valid !== 1'b1 || b_rs2_data !== 32'd0) $display("FAIL bp_load: got v=%0h rs2d=%0h want 1 0", b_valid, b_rs2_data); else passed++;
    i_ex_ready = 1'b0; i_instr = 32'h123452B7; i_pc = 32'h204;  // lui x5,0x12345
    i_wb_we = 1'b1; i_wb_rd = 5'd2; i_wb_data = 32'h55;
    #1;
    total++; if (b_ready !== 1'b0) $display("FAIL bp_ready0: got %0h want 0", b_ready); else passed++;
    tick();
    i_wb_we = 1'b0;
    total++; if (b_rs2_data !== 32'h55 || n_rs2_data !== 32'h55) $display("FAIL bp_refresh: got %0h/%0h want 55", b_rs2_data, n_rs2_data); else passed++;
    total++; if (b_valid !== 1'b1 || b_rd !== 5'd9 || b_pc !== 32'h200 || b_ready !== 1'b0) $display("FAIL bp_hold1: got v=%0h rd=%0d pc=%0h rdy=%0h", b_valid, b_rd, b_pc, b_ready); else passed++;
    tick();
    total++; if (b_valid !== 1'b1 || b_rs2_data !== 32'h55 || b_pc !== 32'h200 || b_ready !== 1'b0) $display("FAIL bp_hold2: got v=%0h rs2d=%0h pc=%0h rdy=%0h", b_valid, b_rs2_data, b_pc, b_ready); else passed++;
    tick();
    total++; if (b_rd !== 5'd9 || b_rs1_data !== 32'd0 || b_ready !== 1'b0) $display("FAIL bp_hold3: got rd=%0d rs1d=%0h rdy=%0h", b_rd, b_rs1_data, b_ready); else passed++;
    i_ex_ready = 1'b1;
    #1;
    total++; if (b_ready !== 1'b1) $display("FAIL bp_ready1: got %0h want 1", b_ready); else passed++;
    tick();
    i_valid = 1'b0;
    total++; if (b_valid !== 1'b1 || b_pc !== 32'h204 || b_imm !== 32'h12345000) $display("FAIL bp_lui: got v=%0h pc=%0h imm=%0h", b_valid, b_pc, b_imm); else passed++;
    total++; if (b_rd !== 5'd5 || b_rf_we !== 1'b1 || b_rs1 !== 5'd0) $display("FAIL bp_lui_fields: got rd=%0d we=%0h rs1=%0d want 5 1 0", b_rd, b_rf_we, b_rs1); else passed++;
  endtask

  task automatic test_flush();
    i_valid = 1'b1; i_instr = 32'h00500513; i_pc = 32'h300; i_ex_ready = 1'b1;  // addi x10,x0,5
    tick();
    total++; if (b_valid !== 1'b1 || b_imm !== 32'd5) $display("FAIL fl_pre: got v=%0h imm=%0h want 1 5", b_valid, b_imm); else passed++;
    i_ex_ready = 1'b0; i_flush = 1'b1; i_instr = 32'hFE20AE23; i_pc = 32'h304;
    i_wb_we = 1'b1; i_wb_rd = 5'd11; i_wb_data = 32'h77;
    #1;
    total++; if (b_ready !== 1'b1) $display("FAIL fl_ready: got %0h want 1", b_ready); else passed++;
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_wb_we = 1'b0;
    total++; if (b_valid !== 1'b0 || n_valid !== 1'b0) $display("FAIL fl_kill: got %0h/%0h want 0", b_valid, n_valid); else passed++;
    tick();
    total++; if (b_valid !== 1'b0) $display("FAIL fl_discard: got %0h want 0", b_valid); else passed++;
    i_ex_ready = 1'b1; i_valid = 1'b1; i_instr = 32'h00058613; i_pc = 32'h308;  // addi x12,x11,0
    tick();
    i_valid = 1'b0;
    total++; if (b_rs1_data !== 32'h77 || n_rs1_data !== 32'h77) $display("FAIL fl_wb_commit: got %0h/%0h want 77", b_rs1_data, n_rs1_data); else passed++;
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_instr = 32'h123452B7; i_pc = 32'h400;  // lui x5
    tick();
    total++; if (b_valid !== 1'b1 || b_pc !== 32'h400) $display("FAIL b2b_first: got v=%0h pc=%0h want 1 400", b_valid, b_pc); else passed++;
    i_instr = 32'hFE20AE23; i_pc = 32'h404;  // sw x2,-4(x1)
    tick();
    i_valid = 1'b0;
    total++; if (b_valid !== 1'b1 || b_pc !== 32'h404 || b_imm !== 32'hFFFFFFFC) $display("FAIL b2b_sw: got v=%0h pc=%0h imm=%0h", b_valid, b_pc, b_imm); else passed++;
    total++; if (b_rf_we !== 1'b0 || b_rs2 !== 5'd2 || b_rs2_data !== 32'h55 || b_func3 !== 3'd2) $display("FAIL b2b_sw_fields: got we=%0h rs2=%0d rs2d=%0h f3=%0d", b_rf_we, b_rs2, b_rs2_data, b_func3); else passed++;
    tick();
    total++; if (b_valid !== 1'b0) $display("FAIL b2b_drain: got %0h want 0", b_valid); else passed++;
  endtask

  task automatic test_illegal();
    i_valid = 1'b1; i_instr = 32'h00208A33; i_pc = 32'h500;  // add x20,x1,x2
    tick();
    total++; if (e_illegal !== 1'b1 || e_rf_we !== 1'b0 || e_valid !== 1'b1) $display("FAIL ill_rv32e: got ill=%0h we=%0h v=%0h want 1 0 1", e_illegal, e_rf_we, e_valid); else passed++;
    total++; if (b_illegal !== 1'b0 || b_rf_we !== 1'b1) $display("FAIL ill_rv32i_legal: got ill=%0h we=%0h want 0 1", b_illegal, b_rf_we); else passed++;
    i_instr = 32'h0000007F; i_pc = 32'h504;
    tick();
    i_valid = 1'b0;
    total++; if (b_illegal !== 1'b1 || b_rf_we !== 1'b0 || b_is_load !== 1'b0 || b_valid !== 1'b1) $display("FAIL ill_opcode: got ill=%0h we=%0h ld=%0h v=%0h", b_illegal, b_rf_we, b_is_load, b_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_illegal();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
